// File: rtl/sdram_copy_pkg.sv
// rtl/sdram_copy_pkg.sv - shared types and sizes for the SDRAM block-copy feeder
package sdram_copy_pkg;

    localparam int BLOCK_WORDS = 512;
    localparam int IDX_W       = 9;
    localparam int ADDR_W      = 26;
    localparam int BASE_W      = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_READY,
        BUF_COPYING
    } buf_state_e;

    typedef enum logic [1:0] {
        CP_IDLE,
        CP_REQ,
        CP_ARMED,
        CP_XFER
    } copy_state_e;

endpackage

// File: rtl/sdram_copy_feeder_if.sv
// rtl/sdram_copy_feeder_if.sv - download stream and controller copy-port bundle
interface sdram_copy_feeder_if;
    import sdram_copy_pkg::*;

    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [15:0]       dl_data;
    logic              dl_done;
    logic              dl_wait;
    logic              busy;
    logic              cpsel;
    logic [ADDR_W-1:0] cpaddr;
    logic [15:0]       cpdin;
    logic              cprd;
    logic              cpreq;
    logic              cpbusy;

    // Loader plus SDRAM controller side
    modport master (
        output dl_wr, dl_addr, dl_data, dl_done, cprd, cpbusy,
        input  dl_wait, busy, cpsel, cpaddr, cpdin, cpreq
    );

    // Feeder side
    modport slave (
        input  dl_wr, dl_addr, dl_data, dl_done, cprd, cpbusy,
        output dl_wait, busy, cpsel, cpaddr, cpdin, cpreq
    );

endinterface

// File: rtl/sdram_copy_feeder_dpram.sv
// rtl/sdram_copy_feeder_dpram.sv - 1024x16 simple dual-port RAM, one-clock read latency
module copy_dpram (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [9:0]  raddr,
    output logic [15:0] rdata_q
);

    logic [15:0] mem [1024];

    // Write port from the fill side, registered read port for the copy side
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

endmodule

// File: rtl/sdram_copy_feeder.sv
// rtl/sdram_copy_feeder.sv - ping-pong 512-word block assembler feeding the SDRAM copy port
module sdram_copy_feeder
    import sdram_copy_pkg::*;
#(
    parameter logic [15:0] PAD_WORD   = 16'h0000,
    parameter int          FLUSH_IDLE = 0
) (
    input logic               clk,
    input logic               init,
    sdram_copy_feeder_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W:0]   LAST_K    = (IDX_W+1)'(BLOCK_WORDS - 1);
    localparam logic [15:0]      FLUSH_LIM = 16'(FLUSH_IDLE);

    buf_state_e        st_q [2];
    buf_state_e        st_c [2];
    buf_state_e        st_d [2];
    logic [BASE_W-1:0] base_q [2];
    logic [BASE_W-1:0] base_d [2];
    logic [IDX_W:0]    vcnt_q [2];
    logic [IDX_W:0]    vcnt_d [2];
    copy_state_e       cs_q, cs_d;
    logic              fill_sel_q, fill_sel_d;
    logic              next_copy_q, next_copy_d;
    logic              copy_sel_q, copy_sel_d;
    logic [IDX_W:0]    k_q, k_d;
    logic              cpreq_q, cpreq_d;
    logic              cpsel_q, cpsel_d;
    logic              pad_q, pad_d;
    logic [ADDR_W-1:0] cpaddr_q, cpaddr_d;
    logic [15:0]       idle_q, idle_d;

    logic              we;
    logic              tgt;
    logic              wr_ok;
    logic              flush_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [BASE_W-1:0] w_base;
    logic [IDX_W:0]    w_cnt;
    logic [15:0]       ram_q;

    assign w_idx     = bus.dl_addr[IDX_W-1:0];
    assign w_base    = bus.dl_addr[ADDR_W-1:IDX_W];
    assign w_cnt     = {1'b0, w_idx} + 1'b1;
    assign bus.dl_wait = (st_q[fill_sel_q] == BUF_READY) || (st_q[fill_sel_q] == BUF_COPYING);
    assign wr_ok     = bus.dl_wr && !bus.dl_wait;
    assign flush_hit = (FLUSH_IDLE != 0) && (idle_q == FLUSH_LIM) && (st_q[fill_sel_q] == BUF_FILLING);

    assign bus.cpreq  = cpreq_q;
    assign bus.cpsel  = cpsel_q;
    assign bus.cpaddr = cpaddr_q;
    assign bus.cpdin  = pad_q ? PAD_WORD : ram_q;
    assign bus.busy   = (st_q[0] != BUF_EMPTY) || (st_q[1] != BUF_EMPTY) || (cs_q != CP_IDLE);

    // Copy FSM: claims the oldest READY buffer, paces k on cprd, releases or requeues it
    always_comb begin
        st_c        = st_q;
        cs_d        = cs_q;
        k_d         = k_q;
        cpreq_d     = cpreq_q;
        cpsel_d     = cpsel_q;
        cpaddr_d    = cpaddr_q;
        copy_sel_d  = copy_sel_q;
        next_copy_d = next_copy_q;
        pad_d       = pad_q;
        unique case (cs_q)
            CP_IDLE: begin
                pad_d = 1'b1;
                if (st_q[next_copy_q] == BUF_READY && !bus.cpbusy) begin
                    st_c[next_copy_q] = BUF_COPYING;
                    copy_sel_d = next_copy_q;
                    cpsel_d    = 1'b1;
                    cpreq_d    = 1'b1;
                    cpaddr_d   = {base_q[next_copy_q], {IDX_W{1'b0}}};
                    k_d        = '0;
                    pad_d      = (vcnt_q[next_copy_q] == '0);
                    cs_d       = CP_REQ;
                end
            end
            CP_REQ: begin
                if (bus.cprd) begin
                    cpreq_d = 1'b0;
                    k_d     = '0;
                    cs_d    = CP_ARMED;
                end
            end
            CP_ARMED, CP_XFER: begin
                if (bus.cprd) begin
                    k_d   = k_q + 1'b1;
                    pad_d = (k_d >= vcnt_q[copy_sel_q]);
                    cs_d  = CP_XFER;
                end else begin
                    // A window shorter than a full block means the controller gave up: retry later
                    if (cs_q == CP_XFER && k_q == LAST_K) begin
                        st_c[copy_sel_q] = BUF_EMPTY;
                        next_copy_d      = ~next_copy_q;
                    end else begin
                        st_c[copy_sel_q] = BUF_READY;
                    end
                    cpsel_d = 1'b0;
                    pad_d   = 1'b1;
                    k_d     = '0;
                    cs_d    = CP_IDLE;
                end
            end
        endcase
    end

    // Fill side: runs on post-release state so a write can land in a buffer freed this clock
    always_comb begin
        st_d       = st_c;
        base_d     = base_q;
        vcnt_d     = vcnt_q;
        fill_sel_d = fill_sel_q;
        we         = 1'b0;
        tgt        = fill_sel_q;
        idle_d     = (st_q[fill_sel_q] == BUF_FILLING && !bus.dl_wr && !flush_hit) ? idle_q + 16'd1 : 16'd0;
        if (wr_ok) begin
            if (st_c[fill_sel_q] == BUF_FILLING && w_base != base_q[fill_sel_q]) begin
                st_d[fill_sel_q] = BUF_READY;
                tgt        = ~fill_sel_q;
                fill_sel_d = ~fill_sel_q;
                we         = (st_c[~fill_sel_q] == BUF_EMPTY);
            end else begin
                we = 1'b1;
            end
            if (we) begin
                if (st_d[tgt] == BUF_EMPTY) begin
                    base_d[tgt] = w_base;
                    vcnt_d[tgt] = w_cnt;
                    st_d[tgt]   = BUF_FILLING;
                end else if (w_cnt > vcnt_q[tgt]) begin
                    vcnt_d[tgt] = w_cnt;
                end
                if (w_idx == LAST_IDX) begin
                    st_d[tgt]  = BUF_READY;
                    fill_sel_d = ~tgt;
                end
            end
        end
        // After an index-511 close the pointer has moved off the block, so it closes only once
        if ((bus.dl_done || flush_hit) && st_d[fill_sel_d] == BUF_FILLING) begin
            st_d[fill_sel_d] = BUF_READY;
            fill_sel_d       = ~fill_sel_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (init) begin
            st_q        <= '{BUF_EMPTY, BUF_EMPTY};
            base_q      <= '{'0, '0};
            vcnt_q      <= '{'0, '0};
            cs_q        <= CP_IDLE;
            fill_sel_q  <= 1'b0;
            next_copy_q <= 1'b0;
            copy_sel_q  <= 1'b0;
            k_q         <= '0;
            cpreq_q     <= 1'b0;
            cpsel_q     <= 1'b0;
            pad_q       <= 1'b1;
            cpaddr_q    <= '0;
            idle_q      <= '0;
        end else begin
            st_q        <= st_d;
            base_q      <= base_d;
            vcnt_q      <= vcnt_d;
            cs_q        <= cs_d;
            fill_sel_q  <= fill_sel_d;
            next_copy_q <= next_copy_d;
            copy_sel_q  <= copy_sel_d;
            k_q         <= k_d;
            cpreq_q     <= cpreq_d;
            cpsel_q     <= cpsel_d;
            pad_q       <= pad_d;
            cpaddr_q    <= cpaddr_d;
            idle_q      <= idle_d;
        end
    end

    copy_dpram u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   ({tgt, w_idx}),
        .wdata   (bus.dl_data),
        .raddr   ({copy_sel_d, k_d[IDX_W-1:0]}),
        .rdata_q (ram_q)
    );

endmodule

// File: doc/sdram_copy_feeder.md
Name: sdram_copy_feeder

Overview:
- Source end of the SDRAM controller's block-copy port (cpsel/cpaddr/cpdin/cprd/cpreq/cpbusy).
- Accepts a 16-bit word download stream and assembles it into 512-word blocks in a ping-pong buffer (2×512×16 block RAM).
- Issues one copy request per completed block and streams the block to the controller word by word, paced by cprd.
- Sits between the ROM/download loader and the SDRAM controller, so that downloads reach SDRAM as full-page bursts.

Parameters:
- PAD_WORD, 16'h0000, value driven on cpdin for indices of a partial block that were never written.
- FLUSH_IDLE, 0, dl_wr-idle clocks before a partial block is auto-closed; 0 disables auto-close.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- init  in  1  reset; synchronous, active-high.
- dl_wr  in  1  one-clock strobe; write dl_data at dl_addr.
- dl_addr  in  26  word address [26:1]; [9:1] is the index within the block, [26:10] is the block base.
- dl_data  in  16  download word.
- dl_done  in  1  one-clock strobe; close the current partial block.
- dl_wait  out  1  backpressure; dl_wr is ignored while this is high.
- busy  out  1  high while any buffer is filled or copying.
- cpsel  out  1  selects this chip/port for the copy.
- cpaddr  out  26  block base address [26:1] with [9:1]=0.
- cpdin  out  16  copy data word.
- cprd  in  1  controller copy-read window.
- cpreq  out  1  copy request; the controller acts on its rising edge.
- cpbusy  in  1  controller copy busy.

Behaviour:
- Reset (init=1 at a clk edge): both buffers EMPTY; fill pointer on buffer 0; copy FSM IDLE.
  - Output reset values: cpreq=0, cpsel=0, cpaddr=0, cpdin=PAD_WORD, dl_wait=0, busy=0.
  - init mid-copy abandons the copy. The controller completes its 512 writes with whatever cpdin shows; this is acceptable.
- Buffer states: EMPTY -> FILLING -> READY -> COPYING -> EMPTY.
  - Per buffer: base[26:10] and valid_cnt[9:0], the highest written index+1, range 0..512.
- Fill rules:
  - First dl_wr into an EMPTY fill buffer latches its base and sets it FILLING.
  - Write to index 511 -> buffer READY, fill pointer toggles.
  - Write whose base differs from the FILLING base -> current buffer READY; the word goes into the other buffer in the same clock if that buffer is EMPTY. Otherwise dl_wait asserts and the word must be re-presented.
  - dl_done, or FLUSH_IDLE idle clocks, with a FILLING buffer -> READY. dl_done with no FILLING buffer is ignored.
  - dl_wait = (fill buffer not EMPTY and not FILLING). It is asserted combinationally from registered state.
- Copy FSM states: IDLE, REQ, ARMED, XFER.
  - IDLE: when the oldest READY buffer exists and cpbusy=0 -> set cpsel=1, cpaddr=base, cpreq=1; buffer COPYING; go to REQ. Oldest means ping-pong order.
  - REQ: cpreq is held high until cprd=1. On cprd=1 (first window clock): cpreq=0, word index k=0, go to ARMED.
  - ARMED: one clock with cprd=1; cpdin still shows word 0. Go to XFER.
  - XFER: every clock with cprd=1 after the first window clock, k increments. cpdin shows word k, or PAD_WORD when k>=valid_cnt.
  - cprd falls with k==511 -> buffer EMPTY, cpsel=0, go to IDLE.
  - cprd falls with k<511 (controller lost SDRAM_EN) -> buffer back to READY at the queue head; IDLE retries after cpbusy=0.
- cpdin timing: word 0 is valid from the REQ entry clock through the first two cprd-high clocks. It then advances one word per clock; RAM read latency is absorbed by prefetching.
- Simultaneous events:
  - dl_wr and a copy release in the same clock: the release is processed first, so the write may land in the freed buffer.
  - dl_done coinciding with the index-511 write: the buffer is closed once.
- busy = any buffer not EMPTY or FSM not IDLE.

Decomposition:
- Package sdram_copy_pkg: BLOCK_WORDS=512; the index width (9 bits); the buffer-state enum {EMPTY, FILLING, READY, COPYING}; the copy FSM enum.
- Sub-module copy_dpram: 1024×16 simple dual-port RAM with one-clock read latency. The write port is {fill_sel, idx}; the read port is {copy_sel, k}.

Test Plan:
- Write 512 sequential words 0x0000..0x01FF starting at 0x000400 -> one cpreq rise; cpaddr=0x000400; cpdin values 0x0000..0x01FF in the 512 write clocks; busy falls afterward.
- Write 1024 words back to back while the controller is slow -> dl_wait never asserts; two copies in order, with bases 0x000000 then 0x000200.
- Write 10 words at 0x001000, then dl_done -> copy starts; cpdin shows the 10 words, then 502×PAD_WORD.
- Fill both buffers while the controller is stalled (cpbusy held) -> dl_wait=1 and the next dl_wr is dropped; after the first copy finishes, dl_wait=0.
- Drop cprd after 100 words -> the buffer is re-requested after cpbusy=0; the second copy delivers all 512 words starting at word 0.
- Assert init during XFER -> the next clock shows cpreq=0, cpsel=0, busy=0, cpdin=PAD_WORD; a fresh download copies correctly.
